// File: rtl/async_operand_scheduler.sv
// Launches one operand at a time into a dual-rail async datapath and returns a response after return-to-zero.
// Grant-to-response is at least 2+2*SYNC_STAGES cycles; while a response is held unaccepted, no new operand is granted.
module async_operand_scheduler #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    input  logic [DATA_W-1:0] req_data0_i,
    input  logic [DATA_W-1:0] req_data1_i,
    output logic [1:0]        req_ready_o,
    output logic [DATA_W-1:0] src_data_o,
    output logic              src_ack_o,
    input  logic              done_i,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic              rsp_err_o,
    input  logic              rsp_ready_i,
    output logic              busy_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, RTZ, RESP} state_t;

    state_t             r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_arm;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ptr;
    logic               r_id;
    logic               r_err;
    logic               r_src_ack;
    logic [DATA_W-1:0]  r_src_data;
    logic [1:0]         r_req_ready;
    logic               r_rsp_valid;
    logic               r_busy;

    logic               w_done_s;
    logic               w_armed;
    logic               w_grant;
    logic               w_grant_ok;
    logic [DATA_W-1:0]  w_operand;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_done_s   = r_sync[SYNC_STAGES-1];
    // Synchronizer resets to 0, so hold off grants until it has sampled the real done level.
    assign w_armed    = r_arm[SYNC_STAGES-1];
    assign w_grant    = (&req_valid_i) ? r_ptr : req_valid_i[1];
    assign w_grant_ok = (|req_valid_i) && !w_done_s && w_armed;
    assign w_operand  = w_grant ? req_data1_i : req_data0_i;
    assign w_cnt_nxt  = r_cnt + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_arm  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], done_i};
            r_arm  <= {r_arm[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_src_ack   <= 1'b1;
            r_src_data  <= '0;
            r_req_ready <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_req_ready <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_grant_ok) begin
                        r_req_ready <= w_grant ? 2'b10 : 2'b01;
                        r_src_data  <= w_operand;
                        r_id        <= w_grant;
                        r_ptr       <= ~w_grant;
                        r_err       <= 1'b0;
                        r_src_ack   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    r_cnt <= w_cnt_nxt;
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (w_done_s) begin
                        r_err     <= 1'b0;
                        r_src_ack <= 1'b1;
                        r_state   <= RTZ;
                    end else if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                        r_err     <= 1'b1;
                        r_src_ack <= 1'b1;
                        r_state   <= RTZ;
                    end
                end
                RTZ: begin
                    if (!w_done_s) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign src_data_o  = r_src_data;
    assign src_ack_o   = r_src_ack;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_id;
    assign rsp_err_o   = r_err;
    assign busy_o      = r_busy;
endmodule

// File: tb/tb_async_operand_scheduler.sv
// Bench for async_operand_scheduler: randomized and directed transactions against a round-robin reference
// and a delayed-handshake datapath model; a second instance with TIMEOUT=8 exercises the timeout path.
module tb_async_operand_scheduler;
    localparam int DW      = 32;
    localparam int SYNC    = 2;
    localparam int TO_MAIN = 64;
    localparam int TO_T    = 8;
    localparam int MINLAT  = 2 + 2 * SYNC;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [DW-1:0] d0, d1;
    logic [1:0]    req_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_ack_o;
    logic          done_i;
    logic          rsp_valid_o, rsp_id_o, rsp_err_o;
    logic          rsp_ready;
    logic          busy_o;

    logic [1:0]    t_valid;
    logic [DW-1:0] t_d0;
    logic [1:0]    t_req_ready_o;
    logic [DW-1:0] t_src_data_o;
    logic          t_src_ack_o;
    logic          t_rsp_valid_o, t_rsp_id_o, t_rsp_err_o;
    logic          t_rsp_ready;
    logic          t_busy_o;

    int total = 0;
    int bad   = 0;

    logic dp_done, dp_freeze, dp_force;
    int   dly_up, dly_dn;
    int   m_order [2];

    assign done_i = dp_freeze ? dp_force : dp_done;

    async_operand_scheduler #(.DATA_W(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TO_MAIN)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data0_i(d0), .req_data1_i(d1),
        .req_ready_o(req_ready_o), .src_data_o(src_data_o), .src_ack_o(src_ack_o), .done_i(done_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
        .rsp_ready_i(rsp_ready), .busy_o(busy_o));

    async_operand_scheduler #(.DATA_W(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TO_T)) dut_to (
        .clk_i(clk), .rst_i(rst), .req_valid_i(t_valid), .req_data0_i(t_d0), .req_data1_i('0),
        .req_ready_o(t_req_ready_o), .src_data_o(t_src_data_o), .src_ack_o(t_src_ack_o), .done_i(1'b0),
        .rsp_valid_o(t_rsp_valid_o), .rsp_id_o(t_rsp_id_o), .rsp_err_o(t_rsp_err_o),
        .rsp_ready_i(t_rsp_ready), .busy_o(t_busy_o));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: done rises dly_up cycles into the data phase, falls dly_dn cycles into the spacer.
    initial begin
        logic prev;
        int   age;
        dp_done = 1'b0;
        prev    = 1'b1;
        age     = 0;
        forever begin
            @(negedge clk);
            if (src_ack_o !== prev) begin
                prev = src_ack_o;
                age  = 1;
            end else begin
                age++;
            end
            if (!prev && age >= dly_up) dp_done = 1'b1;
            if (prev && age >= dly_dn)  dp_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: service order list; the granted requester moves to the back.
    function automatic int model_pick(input logic [1:0] v);
        int g;
        g = v[m_order[0]] ? m_order[0] : m_order[1];
        if (g == m_order[0]) begin
            m_order[0] = m_order[1];
            m_order[1] = g;
        end
        return g;
    endfunction

    task automatic run_txn(input logic [1:0] v, input logic [DW-1:0] a, input logic [DW-1:0] b, input int bp);
        int g, n, lat, rtz;
        logic [DW-1:0] exp_d;
        bit extra;
        req_valid = v;
        d0        = a;
        d1        = b;
        rsp_ready = 1'b0;
        g     = model_pick(v);
        exp_d = (g == 1) ? b : a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready_o == 2'b00 && n < 100);
        chk("grant", req_ready_o, (g == 1) ? 2'b10 : 2'b01);
        chk("src_data", src_data_o, exp_d);
        chk("ack_launch", src_ack_o, 1'b0);
        @(negedge clk);
        chk("ready_pulse", req_ready_o, 2'b00);
        lat   = 1;
        rtz   = 0;
        n     = 0;
        extra = 0;
        while (!rsp_valid_o && n < 400) begin
            @(negedge clk);
            n++;
            lat++;
            if (src_ack_o) rtz++;
            if (req_ready_o != 2'b00) extra = 1;
        end
        chk("rsp_seen", rsp_valid_o, 1'b1);
        chk("rsp_id", rsp_id_o, g);
        chk("rsp_err", rsp_err_o, 1'b0);
        chk("ack_resp", src_ack_o, 1'b1);
        chk("done_low_at_rsp", done_i, 1'b0);
        chk("min_latency", lat >= MINLAT, 1'b1);
        chk("rtz_hold", rtz >= dly_dn, 1'b1);
        chk("no_extra_ready", extra, 1'b0);
        chk("busy_resp", busy_o, 1'b1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid_o, rsp_id_o, rsp_err_o, req_ready_o}, {1'b1, g[0], 1'b0, 2'b00});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        chk("rsp_drop", rsp_valid_o, 1'b0);
        chk("busy_idle", busy_o, 1'b0);
    endtask

    initial begin
        int n, w, anomalies;
        logic [1:0] v;
        rst = 1'b1;
        req_valid = 2'b00; d0 = '0; d1 = '0; rsp_ready = 1'b0;
        t_valid = 2'b00; t_d0 = '0; t_rsp_ready = 1'b0;
        dp_freeze = 1'b0; dp_force = 1'b0;
        dly_up = 10; dly_dn = 2;
        m_order = '{0, 1};
        repeat (3) @(negedge clk);
        chk("rst_ack", src_ack_o, 1'b1);
        chk("rst_data", src_data_o, '0);
        chk("rst_outs", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o}, '0);
        rst = 1'b0;
        repeat (SYNC + 1) @(negedge clk);

        for (int i = 0; i < 4; i++) run_txn(2'b11, $urandom, $urandom, 0);

        run_txn(2'b01, 32'h4080_0000, $urandom, 0);
        run_txn(2'b11, $urandom, $urandom, 5);
        dly_dn = 20;
        run_txn(2'b10, $urandom, $urandom, 1);

        for (int i = 0; i < 6; i++) begin
            dly_up = $urandom_range(1, 12);
            dly_dn = $urandom_range(1, 6);
            v = 2'($urandom_range(1, 3));
            run_txn(v, $urandom, $urandom, $urandom_range(0, 3));
        end

        t_d0 = $urandom;
        t_valid = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t_req_ready_o == 2'b00 && n < 20);
        t_valid = 2'b00;
        chk("to_grant", t_req_ready_o, 2'b01);
        chk("to_src_data", t_src_data_o, t_d0);
        w = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (t_src_ack_o == 1'b0) w++;
            else break;
        end
        chk("to_wait_cycles", w, TO_T);
        chk("to_ack_rtz", t_src_ack_o, 1'b1);
        chk("to_no_rsp_in_rtz", t_rsp_valid_o, 1'b0);
        @(negedge clk);
        chk("to_rsp", {t_rsp_valid_o, t_rsp_id_o, t_rsp_err_o}, 3'b101);
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        chk("to_rsp_drop", t_rsp_valid_o, 1'b0);

        dly_up = 10;
        dly_dn = 2;
        d0 = $urandom;
        req_valid = 2'b01;
        void'(model_pick(2'b01));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready_o == 2'b00 && n < 20);
        chk("pre_rst_grant", req_ready_o, 2'b01);
        repeat (4) @(negedge clk);
        chk("in_wait", src_ack_o, 1'b0);
        dp_force  = 1'b1;
        dp_freeze = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_ack", src_ack_o, 1'b1);
        chk("arst_data", src_data_o, '0);
        chk("arst_outs", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o}, '0);
        m_order = '{0, 1};
        @(negedge clk);
        rst = 1'b0;
        anomalies = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready_o != 2'b00 || rsp_valid_o) anomalies++;
        end
        chk("no_grant_done_high", anomalies, 0);
        dp_force = 1'b0;
        v = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready_o == 2'b00 && n < 20);
        chk("post_rst_grant", req_ready_o, (model_pick(v) == 1) ? 2'b10 : 2'b01);
        chk("post_rst_sync_wait", n >= SYNC + 1, 1'b1);
        req_valid = 2'b00;
        dp_freeze = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_rsp", {rsp_valid_o, rsp_id_o, rsp_err_o}, 3'b100);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rst_drop", rsp_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
